// File: rtl/store_io_router.sv
// Store-side address decode: byte-lane enables for DMEM/IMEM, UART TX queue,
// and memory-mapped cycle/instret counters with one-cycle IO readback.
module store_io_router #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned TXQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_data,
  input  logic [2:0]        st_funct3,
  input  logic              st_pc30,
  input  logic              inst_retire,
  input  logic              io_ren,
  input  logic [31:0]       io_raddr,
  input  logic              uart_rx_valid,
  input  logic              uart_tx_ready,
  output logic [3:0]        dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_din,
  output logic [3:0]        imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  output logic              uart_tx_valid,
  output logic [7:0]        uart_tx_data,
  output logic [31:0]       io_rdata,
  output logic              stall,
  output logic              st_misalign
);
  localparam int unsigned PTR_W = $clog2(TXQ_DEPTH);
  localparam int unsigned CNT_W = $clog2(TXQ_DEPTH + 1);

  localparam logic [31:0] ADDR_UART_STAT = 32'h8000_0000;
  localparam logic [31:0] ADDR_UART_TX   = 32'h8000_0008;
  localparam logic [31:0] ADDR_CYCLE     = 32'h8000_0010;
  localparam logic [31:0] ADDR_INSTRET   = 32'h8000_0014;
  localparam logic [31:0] ADDR_CNT_CLR   = 32'h8000_0018;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  logic [3:0]       region;
  logic             dmem_hit;
  logic             imem_hit;
  logic             width_ok;
  logic             misalign;
  logic [3:0]       lane_we;
  logic [31:0]      lane_din;

  logic             tx_store;
  logic             cnt_clr;
  logic             txq_full;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       txq_mem [TXQ_DEPTH];

  logic [31:0]      cycle_cnt;
  logic [31:0]      inst_cnt;
  logic [31:0]      io_rd_mux;

  // Region decode: 00x1 DMEM, 001x IMEM (BIOS-only writes); 0011 hits both.
  assign region   = st_addr[31:28];
  assign dmem_hit = (region[3:2] == 2'b00) && region[0];
  assign imem_hit = (region[3:1] == 3'b001) && st_pc30;
  assign width_ok = (st_funct3 == F3_SB) || (st_funct3 == F3_SH) || (st_funct3 == F3_SW);

  // Lane enables and replicated data; misaligned halves/words write nothing.
  always_comb begin
    lane_we  = 4'b0000;
    lane_din = st_data;
    misalign = 1'b0;
    case (st_funct3)
      F3_SB: begin
        lane_we  = 4'b0001 << st_addr[1:0];
        lane_din = {4{st_data[7:0]}};
      end
      F3_SH: begin
        lane_din = {2{st_data[15:0]}};
        if (st_addr[0]) misalign = 1'b1;
        else            lane_we  = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      F3_SW: begin
        if (st_addr[1:0] != 2'b00) misalign = 1'b1;
        else                       lane_we  = 4'b1111;
      end
      default: ;
    endcase
  end

  assign dmem_we   = (rst && st_valid && dmem_hit) ? lane_we : 4'b0000;
  assign imem_we   = (rst && st_valid && imem_hit) ? lane_we : 4'b0000;
  assign dmem_addr = st_addr[ADDR_W+1:2];
  assign imem_addr = st_addr[ADDR_W+1:2];
  assign dmem_din  = lane_din;
  assign imem_din  = lane_din;

  // TX byte push accepts SB or SW only; a full queue stalls rather than drops.
  assign tx_store = st_valid && (st_addr == ADDR_UART_TX) &&
                    ((st_funct3 == F3_SB) || (st_funct3 == F3_SW));
  assign cnt_clr  = st_valid && (st_addr == ADDR_CNT_CLR) && width_ok;
  assign txq_full = (count == CNT_W'(TXQ_DEPTH));
  assign push     = tx_store && !txq_full;
  assign pop      = uart_tx_valid && uart_tx_ready;
  assign stall    = rst && tx_store && txq_full;

  assign uart_tx_valid = rst && (count != '0);
  assign uart_tx_data  = txq_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) txq_mem[wr_ptr] <= st_data[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      case ({push, pop})
        2'b10:   count <= CNT_W'(count + 1'b1);
        2'b01:   count <= CNT_W'(count - 1'b1);
        default: ;
      endcase
    end
  end

  // Clear wins over the same-cycle increments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else if (cnt_clr) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (inst_retire) inst_cnt <= inst_cnt + 32'd1;
    end
  end

  always_comb begin
    io_rd_mux = 32'h0;
    case (io_raddr)
      ADDR_UART_STAT: io_rd_mux = {30'b0, uart_rx_valid, !txq_full};
      ADDR_CYCLE:     io_rd_mux = cycle_cnt;
      ADDR_INSTRET:   io_rd_mux = inst_cnt;
      default: ;
    endcase
  end

  // Registered read port mirrors synchronous-memory latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io_rdata    <= 32'h0;
      st_misalign <= 1'b0;
    end else begin
      if (io_ren) io_rdata <= io_rd_mux;
      st_misalign <= st_valid && misalign;
    end
  end

endmodule

// File: tb/tb_store_io_router.sv
// Self-checking bench for store_io_router: directed table, FIFO/counter/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_store_io_router;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  st_funct3 = '0;
  logic        st_pc30 = 1'b0;
  logic        inst_retire = 1'b0;
  logic        io_ren = 1'b0;
  logic [31:0] io_raddr = '0;
  logic        uart_rx_valid = 1'b0;
  logic        uart_tx_ready = 1'b0;
  logic [3:0]  dmem_we, imem_we;
  logic [13:0] dmem_addr, imem_addr;
  logic [31:0] dmem_din, imem_din, io_rdata;
  logic        uart_tx_valid, stall, st_misalign;
  logic [7:0]  uart_tx_data;

  store_io_router #(.ADDR_W(14), .TXQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_funct3(st_funct3), .st_pc30(st_pc30), .inst_retire(inst_retire),
    .io_ren(io_ren), .io_raddr(io_raddr), .uart_rx_valid(uart_rx_valid),
    .uart_tx_ready(uart_tx_ready), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_din(dmem_din), .imem_we(imem_we), .imem_addr(imem_addr), .imem_din(imem_din),
    .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data), .io_rdata(io_rdata),
    .stall(stall), .st_misalign(st_misalign)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  logic [7:0]  m_q[$];
  logic [31:0] m_cyc = '0;
  logic [31:0] m_inst = '0;
  logic [31:0] m_rdata = '0;
  logic        m_mis = 1'b0;
  logic [7:0]  seen[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    logic        pc30;
    logic [3:0]  dwe;
    logic [3:0]  iwe;
    logic [31:0] din;
    logic [13:0] waddr;
    logic        mis;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cyc = '0;
    m_inst = '0;
    m_rdata = '0;
    m_mis = 1'b0;
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic tick();
    int          size;
    int          off;
    logic        legal, aligned, e_tx, e_full, e_clr;
    logic [3:0]  e_we, e_dwe, e_iwe;
    logic [31:0] e_din;
    logic [3:0]  top;
    #1;
    size    = 1 << st_funct3;
    off     = int'(st_addr[1:0]);
    legal   = st_valid && (st_funct3 <= 3'd2);
    aligned = (off % size) == 0;
    e_we    = (legal && aligned) ? 4'(((1 << size) - 1) << off) : 4'b0;
    e_din   = '0;
    for (int b = 0; b < 4; b++) e_din[b*8 +: 8] = st_data[((b % size) * 8) +: 8];
    top     = st_addr[31:28];
    e_dwe   = (top == 4'd1 || top == 4'd3) ? e_we : 4'b0;
    e_iwe   = ((top == 4'd2 || top == 4'd3) && st_pc30) ? e_we : 4'b0;
    e_tx    = st_valid && st_addr == 32'h8000_0008 && (st_funct3 == 3'd0 || st_funct3 == 3'd2);
    e_clr   = legal && st_addr == 32'h8000_0018;
    e_full  = m_q.size() == DEPTH;

    chk("dmem_we", 32'(dmem_we), 32'(e_dwe));
    chk("imem_we", 32'(imem_we), 32'(e_iwe));
    chk("dmem_addr", 32'(dmem_addr), (st_addr >> 2) & 32'h3FFF);
    chk("imem_addr", 32'(imem_addr), (st_addr >> 2) & 32'h3FFF);
    if (e_dwe != 0) chk("dmem_din", dmem_din, e_din);
    if (e_iwe != 0) chk("imem_din", imem_din, e_din);
    chk("stall", 32'(stall), 32'(e_tx && e_full));
    chk("tx_valid", 32'(uart_tx_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("tx_data", 32'(uart_tx_data), 32'(m_q[0]));
    if (uart_tx_valid && uart_tx_ready) seen.push_back(uart_tx_data);

    if (io_ren) begin
      if (io_raddr == 32'h8000_0000)      m_rdata = {30'b0, uart_rx_valid, !e_full};
      else if (io_raddr == 32'h8000_0010) m_rdata = m_cyc;
      else if (io_raddr == 32'h8000_0014) m_rdata = m_inst;
      else                                m_rdata = '0;
    end
    if (m_q.size() != 0 && uart_tx_ready) void'(m_q.pop_front());
    if (e_tx && !e_full) m_q.push_back(st_data[7:0]);
    if (e_clr) begin
      m_cyc = '0;
      m_inst = '0;
    end else begin
      m_cyc = m_cyc + 32'd1;
      if (inst_retire) m_inst = m_inst + 32'd1;
    end
    m_mis = legal && !aligned;

    @(posedge clk);
    #1;
    chk("io_rdata", io_rdata, m_rdata);
    chk("st_misalign", 32'(st_misalign), 32'(m_mis));
  endtask

  task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                           input logic pc);
    st_valid = 1'b1;
    st_addr = a;
    st_data = d;
    st_funct3 = f3;
    st_pc30 = pc;
  endtask

  task automatic drain();
    st_valid = 1'b0;
    io_ren = 1'b0;
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 20 && m_q.size() != 0; i++) tick();
    chk("drain_empty", 32'(m_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h1000_0003, 32'h0000_00A5, 3'd0, 1'b0, 4'b1000, 4'b0000, 32'hA5A5_A5A5, 14'h0000, 1'b0};
    vecs[1]  = '{32'h2000_0010, 32'h1234_5678, 3'd2, 1'b0, 4'b0000, 4'b0000, 32'h1234_5678, 14'h0004, 1'b0};
    vecs[2]  = '{32'h2000_0010, 32'h1234_5678, 3'd2, 1'b1, 4'b0000, 4'b1111, 32'h1234_5678, 14'h0004, 1'b0};
    vecs[3]  = '{32'h1000_0001, 32'h0000_1111, 3'd1, 1'b0, 4'b0000, 4'b0000, 32'h1111_1111, 14'h0000, 1'b1};
    vecs[4]  = '{32'h3000_0002, 32'hBEEF_CAFE, 3'd1, 1'b1, 4'b1100, 4'b1100, 32'hCAFE_CAFE, 14'h0000, 1'b0};
    vecs[5]  = '{32'h3000_0004, 32'hDEAD_BEEF, 3'd2, 1'b0, 4'b1111, 4'b0000, 32'hDEAD_BEEF, 14'h0001, 1'b0};
    vecs[6]  = '{32'h1000_0002, 32'hDEAD_BEEF, 3'd2, 1'b0, 4'b0000, 4'b0000, 32'hDEAD_BEEF, 14'h0000, 1'b1};
    vecs[7]  = '{32'h0000_0001, 32'h0000_005A, 3'd0, 1'b1, 4'b0000, 4'b0000, 32'h5A5A_5A5A, 14'h0000, 1'b0};
    vecs[8]  = '{32'h5000_0000, 32'h0000_005A, 3'd0, 1'b1, 4'b0000, 4'b0000, 32'h5A5A_5A5A, 14'h0000, 1'b0};
    vecs[9]  = '{32'h1000_0000, 32'hFFFF_FFFF, 3'd3, 1'b0, 4'b0000, 4'b0000, 32'hFFFF_FFFF, 14'h0000, 1'b0};
    vecs[10] = '{32'h1000_0000, 32'h0000_ABCD, 3'd1, 1'b0, 4'b0011, 4'b0000, 32'hABCD_ABCD, 14'h0000, 1'b0};
    vecs[11] = '{32'h1000_FFF6, 32'h0000_0077, 3'd0, 1'b0, 4'b0100, 4'b0000, 32'h7777_7777, 14'h3FFD, 1'b0};

    // Reset state, with a legal store presented while reset is held
    set_store(32'h3000_0000, 32'h1, 3'd2, 1'b1);
    @(posedge clk);
    #1;
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_tx_valid", 32'(uart_tx_valid), 32'd0);
    chk("rst_io_rdata", io_rdata, 32'd0);
    chk("rst_misalign", 32'(st_misalign), 32'd0);
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    rst = 1'b1;
    model_reset();

    // Directed lane/region table
    for (int i = 0; i < 12; i++) begin
      set_store(vecs[i].addr, vecs[i].data, vecs[i].f3, vecs[i].pc30);
      #1;
      chk($sformatf("vec%0d_dwe", i), 32'(dmem_we), 32'(vecs[i].dwe));
      chk($sformatf("vec%0d_iwe", i), 32'(imem_we), 32'(vecs[i].iwe));
      chk($sformatf("vec%0d_waddr", i), 32'(dmem_addr), 32'(vecs[i].waddr));
      if (vecs[i].dwe != 0) chk($sformatf("vec%0d_din", i), dmem_din, vecs[i].din);
      tick();
      chk($sformatf("vec%0d_mis", i), 32'(st_misalign), 32'(vecs[i].mis));
    end

    // TX FIFO fill, stall, and ordered drain
    drain();
    seen.delete();
    uart_tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      set_store(32'h8000_0008, 32'(i), 3'd0, 1'b0);
      #1;
      chk($sformatf("fill%0d_stall", i), 32'(stall), (i == 5) ? 32'd1 : 32'd0);
      if (i < 5) tick();
    end
    uart_tx_ready = 1'b1;
    #1;
    chk("stall_first_pop", 32'(stall), 32'd1);
    tick();
    #1;
    chk("stall_after_pop", 32'(stall), 32'd0);
    tick();
    st_valid = 1'b0;
    for (int i = 0; i < 20 && seen.size() < 5; i++) tick();
    chk("tx_count", 32'(seen.size()), 32'd5);
    if (seen.size() >= 5)
      for (int i = 0; i < 5; i++) chk($sformatf("tx_order%0d", i), 32'(seen[i]), 32'(i + 1));

    // Counters: 100 cycles, alternating retire, then clear semantics
    uart_tx_ready = 1'b0;
    inst_retire = 1'b0;
    set_store(32'h8000_0018, 32'h0, 3'd2, 1'b0);
    tick();
    st_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      inst_retire = (i % 2) == 0;
      tick();
    end
    inst_retire = 1'b0;
    io_ren = 1'b1;
    io_raddr = 32'h8000_0010;
    tick();
    chk("cycle_100", io_rdata, 32'd100);
    io_raddr = 32'h8000_0014;
    tick();
    chk("inst_50", io_rdata, 32'd50);
    io_ren = 1'b0;
    set_store(32'h8000_0018, 32'h0, 3'd0, 1'b0);
    tick();
    st_valid = 1'b0;
    tick();
    io_ren = 1'b1;
    io_raddr = 32'h8000_0010;
    tick();
    chk("cycle_after_clr", io_rdata, 32'd1);
    set_store(32'h8000_0018, 32'h0, 3'd1, 1'b0);
    tick();
    chk("read_pre_clr", io_rdata, 32'd2);
    st_valid = 1'b0;
    io_raddr = 32'h8000_0000;
    uart_rx_valid = 1'b1;
    tick();
    chk("status_read", io_rdata, 32'd3);
    io_ren = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0008;
        1: a = 32'h8000_0008;
        2: a = ($urandom_range(0, 15) == 0) ? 32'h8000_0018 : 32'h8000_0000;
        3: a = 32'h1000_0000 | ($urandom & 32'hFFFF);
        4: a = 32'h2000_0000 | ($urandom & 32'hFFFF);
        5: a = 32'h3000_0000 | ($urandom & 32'hFFFF);
        default: a = $urandom;
      endcase
      st_valid = $urandom_range(0, 3) != 0;
      st_addr = a;
      st_data = $urandom;
      st_funct3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      st_pc30 = 1'($urandom_range(0, 1));
      inst_retire = 1'($urandom_range(0, 1));
      io_ren = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: io_raddr = 32'h8000_0000;
        1: io_raddr = 32'h8000_0010;
        2: io_raddr = 32'h8000_0014;
        3: io_raddr = 32'h8000_0008;
        default: io_raddr = $urandom;
      endcase
      uart_rx_valid = 1'($urandom_range(0, 1));
      uart_tx_ready = $urandom_range(0, 2) == 0;
      tick();
    end

    // Asynchronous reset mid-transmission with three bytes queued
    drain();
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_store(32'h8000_0008, 32'h40 + 32'(i), 3'd2, 1'b0);
      tick();
    end
    st_valid = 1'b0;
    io_ren = 1'b1;
    io_raddr = 32'h8000_0010;
    tick();
    chk("q3_before_rst", 32'(uart_tx_valid), 32'd1);
    io_ren = 1'b0;
    set_store(32'h1000_0000, 32'hCAFE_F00D, 3'd2, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    chk("async_tx_valid", 32'(uart_tx_valid), 32'd0);
    chk("async_io_rdata", io_rdata, 32'd0);
    chk("async_dmem_we", 32'(dmem_we), 32'd0);
    chk("async_misalign", 32'(st_misalign), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    st_valid = 1'b0;
    model_reset();
    io_ren = 1'b1;
    io_raddr = 32'h8000_0010;
    tick();
    chk("cycle_post_rst", io_rdata, 32'd0);
    io_raddr = 32'h8000_0014;
    tick();
    chk("inst_post_rst", io_rdata, 32'd0);
    io_ren = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/store_io_router.md
Name: store_io_router

Overview:
- Write-direction counterpart of the core's writeback/readback selection.
- Takes one store per cycle from the MEM stage and decodes its address.
- Produces byte-lane write enables and aligned data for DMEM and IMEM, and pushes UART transmit bytes into a small FIFO.
- Owns the memory-mapped cycle and retired-instruction counters, and returns IO read data one cycle after a load, matching synchronous-memory latency.

Parameters:
- ADDR_W, 14, word-address width driven to DMEM/IMEM (byte address bits [ADDR_W+1:2]).
- TXQ_DEPTH, 4, UART TX FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous and active-low (one clock, no other domains).
- st_valid  in  1  store request this cycle.
- st_addr  in  32  store byte address.
- st_data  in  32  rs2 value, unaligned.
- st_funct3  in  3  000 SB, 001 SH, 010 SW; other codes are ignored.
- st_pc30  in  1  PC[30] of the storing instruction (1 = executing from BIOS).
- inst_retire  in  1  one instruction retired this cycle.
- io_ren  in  1  load from IO space this cycle.
- io_raddr  in  32  load byte address.
- uart_rx_valid  in  1  RX byte available; status bit only.
- uart_tx_ready  in  1  UART transmitter accepts a byte.
- dmem_we  out  4  DMEM byte write enables.
- dmem_addr  out  ADDR_W  DMEM word address.
- dmem_din  out  32  lane-replicated data.
- imem_we  out  4  IMEM byte write enables.
- imem_addr  out  ADDR_W  IMEM word address.
- imem_din  out  32  lane-replicated data.
- uart_tx_valid  out  1  FIFO head valid.
- uart_tx_data  out  8  FIFO head byte.
- io_rdata  out  32  registered IO read data.
- stall  out  1  store to TX register while FIFO full; the core holds the store.
- st_misalign  out  1  registered one-cycle pulse: store dropped for misalignment.

Behaviour:
- Reset (rst low, async): FIFO empty, cycle_cnt=0, inst_cnt=0, io_rdata=0, st_misalign=0.
- Combinational outputs during reset: dmem_we, imem_we and stall read 0; uart_tx_valid=0.
- Region decode on st_addr[31:28]:
  - 00x1: DMEM.
  - 001x: IMEM, written only if st_pc30=1.
  - 1000: IO.
  - 0011 hits both DMEM and IMEM; both are written when legal.
  - Anything else: no write.
- Lane generation, all combinational the same cycle, since memories sample at the edge:
  - SB: we = 1 << addr[1:0]; din = {4{data[7:0]}}.
  - SH: addr[0]=1 is misaligned; else we = addr[1] ? 1100 : 0011; din = {2{data[15:0]}}.
  - SW: addr[1:0] != 0 is misaligned; else we = 1111; din = data.
- Misaligned store: all enables 0, no FIFO push, st_misalign=1 on the next cycle.
- IO writes:
  - 0x80000008 (SB or SW): push data[7:0] into the FIFO.
  - 0x80000018 (any width): cycle_cnt and inst_cnt both become 0 at the edge; that cycle's increments are discarded.
  - Other IO addresses: ignored.
- TX FIFO:
  - count 0..TXQ_DEPTH.
  - uart_tx_valid = count != 0; uart_tx_data = head.
  - Pop on uart_tx_valid & uart_tx_ready.
  - Push when TX store and count < TXQ_DEPTH.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pointers wrap modulo TXQ_DEPTH.
- stall = st_valid & TX-store & count == TXQ_DEPTH.
  - No push while full, even if a pop occurs that cycle.
  - The store retries next cycle and then succeeds.
- Counters:
  - cycle_cnt +1 every cycle.
  - inst_cnt +1 when inst_retire.
  - Both are 32-bit and wrap 0xFFFFFFFF -> 0.
- IO reads: io_ren sampled; io_rdata valid the next cycle, else holds its last value. Map:
  - 0x80000000 -> {30'b0, uart_rx_valid, count != TXQ_DEPTH}.
  - 0x80000010 -> cycle_cnt.
  - 0x80000014 -> inst_cnt.
  - Other addresses -> 0.
  - Read and counter reset in the same cycle: the read returns the pre-reset value.

Test Plan:
- SB addr 0x10000003 data 0xA5 -> dmem_we=1000, dmem_din=0xA5A5A5A5, dmem_addr=0, imem_we=0.
- SW addr 0x20000010 with st_pc30=0 -> imem_we=0000; repeat with st_pc30=1 -> imem_we=1111, imem_addr=4.
- SH addr 0x10000001 -> all enables 0, st_misalign=1 for exactly one cycle.
- uart_tx_ready=0; five SB to 0x80000008 (bytes 1..5) -> stall=1 on the fifth. Raise ready -> bytes 1..5 emerge in order, stall drops the cycle after the first pop.
- Run 100 cycles with inst_retire every other cycle, read 0x80000010 and 0x80000014 -> 100 / 50 the following cycle. Store to 0x80000018, then read 0x80000010 -> 1.
- Assert rst mid-transmission with 3 bytes queued -> uart_tx_valid=0 and counters 0 immediately, without waiting for clk.
